// File: rtl/dds_pkg.sv
// Shared constants, FSM encoding and helpers for the DDS command-frame parser.
`timescale 1ns/1ps
package dds_pkg;

   localparam logic [7:0] WF_SQU      = 8'd1;
   localparam logic [7:0] WF_SIN      = 8'd2;
   localparam logic [7:0] WF_TRI      = 8'd3;
   localparam logic [7:0] HDR_DEFAULT = 8'hA5;
   localparam int unsigned FRAME_LEN  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAVE = 3'd1,
      ST_FREQ = 3'd2,
      ST_AMP  = 3'd3,
      ST_CHK  = 3'd4
   } state_t;

   function automatic logic wave_valid(input logic [7:0] w);
      return (w >= WF_SQU) && (w <= WF_TRI);
   endfunction

endpackage

// File: rtl/dds_gap_timer.sv
// Inter-byte gap counter: cleared by clr or while disabled, pulses timeout
// on the cycle the gap reaches TIMEOUT_CYC.
`timescale 1ns/1ps
module dds_gap_timer #(
   parameter int unsigned TIMEOUT_CYC = 24000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires one count early so the FSM acts on the TIMEOUT_CYC-th edge.
   assign timeout = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dds_frame_ctrl.sv
// Command-frame parser: collects WAVE/FREQ/AMP into shadow registers and
// commits them atomically to the DDS outputs only after a good checksum.
`timescale 1ns/1ps
module dds_frame_ctrl
   import dds_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 24000,
   parameter logic [7:0]  HDR_BYTE    = HDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cs_n,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic [7:0]  pic_dat,
   output logic [23:0] fre_dat,
   output logic [15:0] amp_dat,
   output logic        SPI_OK,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic [2:0]  dbg_state
);

   // Byte interface: a byte is taken on any edge where byte_vld is high and
   // cs_n is low; there is no back-pressure, so bytes arriving while an abort
   // or timeout is being handled are simply dropped.

   state_t      state;
   logic [1:0]  idx;
   logic [7:0]  chk_acc;
   logic [7:0]  sh_wave;
   logic [23:0] sh_fre;
   logic [15:0] sh_amp;
   logic        cs_q;
   logic        tmo;
   logic        abort;
   logic        tmo_hit;
   logic        take;
   logic        commit;
   logic        err_evt;

   dds_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (take),
      .en      (state != ST_IDLE),
      .timeout (tmo)
   );

   // Event priority: cs_n abort, then timeout, then the byte itself.
   always_comb begin
      abort   = (state != ST_IDLE) && cs_n && !cs_q;
      tmo_hit = tmo && !abort;
      take    = byte_vld && !cs_n && !abort && !tmo_hit;
      commit  = take && (state == ST_CHK) && (byte_dat == chk_acc) && wave_valid(sh_wave);
      err_evt = abort || tmo_hit || (take && (state == ST_CHK) && !commit);
   end

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= 2'd0;
         chk_acc   <= 8'd0;
         sh_wave   <= 8'd0;
         sh_fre    <= 24'd0;
         sh_amp    <= 16'd0;
         cs_q      <= 1'b1;
         pic_dat   <= WF_SIN;
         fre_dat   <= 24'd0;
         amp_dat   <= 16'd0;
         SPI_OK    <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         cs_q      <= cs_n;
         frame_ok  <= commit;
         frame_err <= err_evt;
         if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (commit) begin
            pic_dat <= sh_wave;
            fre_dat <= sh_fre;
            amp_dat <= sh_amp;
            SPI_OK  <= 1'b1;
         end
         if (abort || tmo_hit) begin
            state <= ST_IDLE;
         end else if (take) begin
            unique case (state)
               ST_IDLE: begin
                  if (byte_dat == HDR_BYTE) begin
                     state   <= ST_WAVE;
                     chk_acc <= 8'd0;
                  end
               end
               ST_WAVE: begin
                  sh_wave <= byte_dat;
                  chk_acc <= chk_acc ^ byte_dat;
                  idx     <= 2'd0;
                  state   <= ST_FREQ;
               end
               ST_FREQ: begin
                  sh_fre  <= {sh_fre[15:0], byte_dat};
                  chk_acc <= chk_acc ^ byte_dat;
                  if (idx == 2'd2) begin
                     idx   <= 2'd0;
                     state <= ST_AMP;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
               ST_AMP: begin
                  sh_amp  <= {sh_amp[7:0], byte_dat};
                  chk_acc <= chk_acc ^ byte_dat;
                  if (idx == 2'd1) begin
                     idx   <= 2'd0;
                     state <= ST_CHK;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
               ST_CHK:  state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
